// File: rtl/bram_byte_access_master.sv
// rtl/bram_byte_access_master.sv - byte-addressed load/store requester port for a byte-enable BRAM
//
// Purpose:
//   Takes byte/half/word load and store requests from an LSU and drives one
//   word-addressed BRAM access per request. Stores are lane-replicated with a
//   byte-enable mask. Loads are extracted from the returned word and then
//   sign- or zero-extended. Illegal sizes and misaligned accesses are answered
//   with resp_error and never reach the BRAM.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_write, req_size   store/load select; 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          load extension select (ignored for word loads)
//   req_addr, req_wdata   byte address, right-justified store data
//   resp_valid/resp_ready response handshake
//   resp_rdata, resp_error load result (0 for stores/errors), error flag
//   readEnable, readAddress, readData                        BRAM read port
//   writeEnable, writeByteEnable, writeAddress, writeData    BRAM write port

module bram_byte_access_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_error,
  output logic                    readEnable,
  output logic [ADDR_WIDTH-1:0]   readAddress,
  input  logic [DATA_WIDTH-1:0]   readData,
  output logic                    writeEnable,
  output logic [NUM_BYTES-1:0]    writeByteEnable,
  output logic [ADDR_WIDTH-1:0]   writeAddress,
  output logic [DATA_WIDTH-1:0]   writeData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } stateType;

  stateType state, stateNext;

  logic                  readyNext;
  logic                  readEnableNext;
  logic                  writeEnableNext;
  logic                  respValidNext;
  logic                  respErrorNext;
  logic [ADDR_WIDTH-1:0] readAddressNext;
  logic [ADDR_WIDTH-1:0] writeAddressNext;
  logic [NUM_BYTES-1:0]  writeByteEnableNext;
  logic [DATA_WIDTH-1:0] writeDataNext;
  logic [DATA_WIDTH-1:0] respRdataNext;

  // Request fields kept for the load extraction done in WAIT.
  logic [1:0] latSize, latSizeNext;
  logic [1:0] latOffset, latOffsetNext;
  logic       latUnsigned, latUnsignedNext;
  logic       latWrite, latWriteNext;

  logic [ADDR_WIDTH-1:0] reqWordAddr;
  logic [1:0]            reqOffset;
  logic                  reqIllegal;
  logic                  accept;
  logic [NUM_BYTES-1:0]  laneMask;
  logic [DATA_WIDTH-1:0] laneData;
  logic [7:0]            loadByte;
  logic [15:0]           loadHalf;
  logic [DATA_WIDTH-1:0] loadValue;

  assign reqWordAddr = req_addr[ADDR_WIDTH+1:2];
  assign reqOffset   = req_addr[1:0];
  assign accept      = req_valid & req_ready;

  assign reqIllegal = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && reqOffset[0]) ||
                      ((req_size == 2'b10) && (reqOffset != 2'b00));

  // Store steering: replicate the narrow datum on every lane and let the
  // byte-enable mask pick the lane(s) the address points at.
  always_comb begin
    laneMask = '1;
    laneData = req_wdata;
    case (req_size)
      2'b00: begin
        laneMask = NUM_BYTES'(1) << reqOffset;
        laneData = {NUM_BYTES{req_wdata[7:0]}};
      end
      2'b01: begin
        laneMask = NUM_BYTES'(3) << reqOffset;
        laneData = {(NUM_BYTES / 2){req_wdata[15:0]}};
      end
      default: begin
        laneMask = '1;
        laneData = req_wdata;
      end
    endcase
  end

  // Load extraction from the word returned by the BRAM.
  assign loadByte = readData[{latOffset, 3'b000} +: 8];
  assign loadHalf = readData[{latOffset[1], 4'b0000} +: 16];

  always_comb begin
    loadValue = readData;
    case (latSize)
      2'b00: loadValue = latUnsigned ? {{(DATA_WIDTH-8){1'b0}}, loadByte}
                                     : {{(DATA_WIDTH-8){loadByte[7]}}, loadByte};
      2'b01: loadValue = latUnsigned ? {{(DATA_WIDTH-16){1'b0}}, loadHalf}
                                     : {{(DATA_WIDTH-16){loadHalf[15]}}, loadHalf};
      default: loadValue = readData;
    endcase
  end

  // Next-state and next-output logic. Every output is a register, so the
  // strobes for an access are loaded on the accept edge and are therefore
  // high during the ISSUE cycle; they drop on the edge that leaves ISSUE.
  always_comb begin
    stateNext           = state;
    readyNext           = 1'b0;
    readEnableNext      = 1'b0;
    writeEnableNext     = 1'b0;
    writeByteEnableNext = '0;
    readAddressNext     = readAddress;
    writeAddressNext    = writeAddress;
    writeDataNext       = writeData;
    respValidNext       = resp_valid;
    respRdataNext       = resp_rdata;
    respErrorNext       = resp_error;
    latSizeNext         = latSize;
    latOffsetNext       = latOffset;
    latUnsignedNext     = latUnsigned;
    latWriteNext        = latWrite;

    case (state)
      IDLE: begin
        readyNext = 1'b1;
        if (accept) begin
          readyNext       = 1'b0;
          latSizeNext     = req_size;
          latOffsetNext   = reqOffset;
          latUnsignedNext = req_unsigned;
          latWriteNext    = req_write;
          if (reqIllegal) begin
            stateNext     = RESP;
            respValidNext = 1'b1;
            respErrorNext = 1'b1;
            respRdataNext = '0;
          end else begin
            stateNext = ISSUE;
            if (req_write) begin
              writeEnableNext     = 1'b1;
              writeAddressNext    = reqWordAddr;
              writeByteEnableNext = laneMask;
              writeDataNext       = laneData;
            end else begin
              readEnableNext  = 1'b1;
              readAddressNext = reqWordAddr;
            end
          end
        end
      end

      ISSUE: begin
        if (latWrite) begin
          stateNext     = RESP;
          respValidNext = 1'b1;
          respErrorNext = 1'b0;
          respRdataNext = '0;
        end else begin
          stateNext = WAIT;
        end
      end

      // readData for the strobe sampled at the end of ISSUE is present now.
      WAIT: begin
        stateNext     = RESP;
        respValidNext = 1'b1;
        respErrorNext = 1'b0;
        respRdataNext = loadValue;
      end

      RESP: begin
        if (resp_ready) begin
          stateNext     = IDLE;
          respValidNext = 1'b0;
          respErrorNext = 1'b0;
          respRdataNext = '0;
          readyNext     = 1'b1;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      req_ready       <= 1'b0;
      readEnable      <= 1'b0;
      readAddress     <= '0;
      writeEnable     <= 1'b0;
      writeByteEnable <= '0;
      writeAddress    <= '0;
      writeData       <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_error      <= 1'b0;
      latSize         <= 2'b00;
      latOffset       <= 2'b00;
      latUnsigned     <= 1'b0;
      latWrite        <= 1'b0;
    end else begin
      state           <= stateNext;
      req_ready       <= readyNext;
      readEnable      <= readEnableNext;
      readAddress     <= readAddressNext;
      writeEnable     <= writeEnableNext;
      writeByteEnable <= writeByteEnableNext;
      writeAddress    <= writeAddressNext;
      writeData       <= writeDataNext;
      resp_valid      <= respValidNext;
      resp_rdata      <= respRdataNext;
      resp_error      <= respErrorNext;
      latSize         <= latSizeNext;
      latOffset       <= latOffsetNext;
      latUnsigned     <= latUnsignedNext;
      latWrite        <= latWriteNext;
    end
  end

endmodule

// File: tb/tb_bram_byte_access_master.sv
// tb/tb_bram_byte_access_master.sv - scoreboard bench for bram_byte_access_master

module tb_bram_byte_access_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        readEnable;
  logic [7:0]  readAddress;
  logic [31:0] readData;
  logic        writeEnable;
  logic [3:0]  writeByteEnable;
  logic [7:0]  writeAddress;
  logic [31:0] writeData;

  int checks = 0;
  int errors = 0;
  int rdCount = 0;
  int wrCount = 0;
  int lastPolls = 0;
  logic [3:0]  lastWbe = '0;
  logic [31:0] lastWdata = '0;
  logic [7:0]  lastWaddr = '0;
  logic [32:0] expQ[$];

  logic [31:0] mem [0:255];
  logic        preloadEn = 1'b0;
  logic [7:0]  preloadAddr = '0;
  logic [31:0] preloadData = '0;

  bram_byte_access_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .readEnable(readEnable), .readAddress(readAddress), .readData(readData),
    .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
    .writeAddress(writeAddress), .writeData(writeData)
  );

  always #5 clock = ~clock;

  // BRAM with byte enables and a one-cycle registered read.
  always @(posedge clock) begin
    if (preloadEn) mem[preloadAddr] <= preloadData;
    if (readEnable) readData <= mem[readAddress];
    if (writeEnable) begin
      for (int b = 0; b < 4; b++)
        if (writeByteEnable[b]) mem[writeAddress][8*b +: 8] <= writeData[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Strobe monitor and response scoreboard.
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (readEnable) rdCount++;
        if (writeEnable) begin
          wrCount++;
          lastWbe   = writeByteEnable;
          lastWdata = writeData;
          lastWaddr = writeAddress;
        end
        if (readEnable || writeEnable) check("strobe_exclusive", 32'(readEnable & writeEnable), 32'd0);
        if (resp_valid && resp_ready) begin
          if (expQ.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
          else begin
            e = expQ.pop_front();
            check("resp_rdata", resp_rdata, e[31:0]);
            check("resp_error", 32'(resp_error), 32'(e[32]));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  // Called and returns at posedge+1 with the DUT idle.
  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    preloadAddr = a;
    preloadData = d;
    preloadEn   = 1'b1;
    @(posedge clock);
    #1 preloadEn = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the response handshake.
  task automatic doReq(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wd,
                       input logic [31:0] expData, input logic expErr, input int expLat,
                       input int expRd, input int expWr, input logic [3:0] expWbe,
                       input logic [31:0] expWdata, input int hold, input string tag);
    int rd0, wr0, polls, lat;
    logic acc;
    rd0 = rdCount;
    wr0 = wrCount;
    expQ.push_back({expErr, expData});
    resp_ready   = (hold == 0);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
    acc = 1'b0;
    polls = 0;
    while (!acc && polls < 20) begin
      @(negedge clock);
      acc = req_ready;
      polls++;
      @(posedge clock);
    end
    #1 req_valid = 1'b0;
    lastPolls = polls;
    if (!acc) begin
      check({tag, "_accept"}, 32'd0, 32'd1);
      void'(expQ.pop_back());
      return;
    end
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!resp_valid && lat < 20);
    check({tag, "_latency"}, lat, expLat);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clock);
        @(negedge clock);
        check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_hold_rdata"}, resp_rdata, expData);
        check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      @(posedge clock);
      #1 resp_ready = 1'b1;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    check({tag, "_reads"}, rdCount - rd0, expRd);
    check({tag, "_writes"}, wrCount - wr0, expWr);
    if (expWr == 1) begin
      check({tag, "_wbe"}, 32'(lastWbe), 32'(expWbe));
      check({tag, "_wdata"}, lastWdata, expWdata);
      check({tag, "_waddr"}, 32'(lastWaddr), 32'(addr[9:2]));
    end
  endtask

  initial begin
    int wr0;
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_read_en", 32'(readEnable), 32'd0);
    check("rst_write_en", 32'(writeEnable), 32'd0);
    check("rst_wbe", 32'(writeByteEnable), 32'd0);
    check("rst_read_addr", 32'(readAddress), 32'd0);
    check("rst_write_addr", 32'(writeAddress), 32'd0);
    check("rst_write_data", writeData, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;

    // Reset during ISSUE of a byte store: the write must never reach the BRAM.
    preload(8'd0, 32'h11223344);
    wr0 = wrCount;
    req_write = 1'b1; req_size = 2'b00; req_addr = 10'h000; req_wdata = 32'h55; req_valid = 1'b1;
    @(negedge clock);
    check("abort_accept", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1 reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    check("abort_write_en", 32'(writeEnable), 32'd0);
    check("abort_wbe", 32'(writeByteEnable), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort_ready_after_release", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    check("abort_mem_intact", mem[0], 32'h11223344);
    check("abort_no_write", wrCount - wr0, 32'd0);

    // wr sz uns addr wdata | expData err lat rd wr wbe wdata hold tag
    preload(8'd2, 32'hAAAA8888);
    doReq(1'b0, 2'b10, 1'b0, 10'h008, 32'h0, 32'hAAAA8888, 1'b0, 3, 1, 0, 4'h0, 32'h0, 0, "ld_word");

    preload(8'd2, 32'h00000064);
    doReq(1'b1, 2'b00, 1'b0, 10'h00B, 32'h123456BB, 32'h0, 1'b0, 2, 0, 1, 4'b1000, 32'hBBBBBBBB, 0, "st_byte");
    doReq(1'b0, 2'b10, 1'b0, 10'h008, 32'h0, 32'hBB000064, 1'b0, 3, 1, 0, 4'h0, 32'h0, 0, "ld_after_st_byte");

    preload(8'd2, 32'hCCCC8888);
    doReq(1'b0, 2'b01, 1'b0, 10'h008, 32'h0, 32'hFFFF8888, 1'b0, 3, 1, 0, 4'h0, 32'h0, 0, "ld_half_s");
    doReq(1'b0, 2'b01, 1'b1, 10'h00A, 32'h0, 32'h0000CCCC, 1'b0, 3, 1, 0, 4'h0, 32'h0, 0, "ld_half_u");
    doReq(1'b0, 2'b00, 1'b0, 10'h009, 32'h0, 32'hFFFFFF88, 1'b0, 3, 1, 0, 4'h0, 32'h0, 0, "ld_byte_s");
    doReq(1'b0, 2'b00, 1'b1, 10'h00B, 32'h0, 32'h000000CC, 1'b0, 3, 1, 0, 4'h0, 32'h0, 0, "ld_byte_u");
    doReq(1'b0, 2'b10, 1'b1, 10'h008, 32'h0, 32'hCCCC8888, 1'b0, 3, 1, 0, 4'h0, 32'h0, 0, "ld_word_u");

    doReq(1'b0, 2'b01, 1'b0, 10'h005, 32'h0, 32'h0, 1'b1, 1, 0, 0, 4'h0, 32'h0, 0, "err_half_mis");
    doReq(1'b1, 2'b11, 1'b0, 10'h008, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 0, 4'h0, 32'h0, 0, "err_size11");
    doReq(1'b0, 2'b10, 1'b0, 10'h00A, 32'h0, 32'h0, 1'b1, 1, 0, 0, 4'h0, 32'h0, 0, "err_word_mis");

    preload(8'd3, 32'h00000000);
    doReq(1'b1, 2'b01, 1'b0, 10'h00E, 32'hFFFF1234, 32'h0, 1'b0, 2, 0, 1, 4'b1100, 32'h12341234, 0, "st_half");
    doReq(1'b0, 2'b10, 1'b0, 10'h00C, 32'h0, 32'h12340000, 1'b0, 3, 1, 0, 4'h0, 32'h0, 0, "ld_after_st_half");

    doReq(1'b1, 2'b10, 1'b0, 10'h3FC, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 4'b1111, 32'hDEADBEEF, 0, "st_word_top");
    doReq(1'b0, 2'b00, 1'b1, 10'h3FF, 32'h0, 32'h000000DE, 1'b0, 3, 1, 0, 4'h0, 32'h0, 0, "ld_byte_top");

    // Back-pressure, then an immediate follow-up request.
    doReq(1'b0, 2'b10, 1'b0, 10'h00C, 32'h0, 32'h12340000, 1'b0, 3, 1, 0, 4'h0, 32'h0, 5, "ld_backpressure");
    doReq(1'b0, 2'b01, 1'b1, 10'h00E, 32'h0, 32'h00001234, 1'b0, 3, 1, 0, 4'h0, 32'h0, 0, "ld_after_bp");
    check("accept_next_cycle", lastPolls, 32'd1);

    repeat (3) @(posedge clock);
    check("scoreboard_empty", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_byte_access_master.md
Name: bram_byte_access_master

Overview:
- Requester-side port controller that drives a BRAM_byte_en-style memory: readEnable/readAddress/readData plus writeEnable/writeByteEnable/writeAddress/writeData.
- Converts byte-addressed load/store requests (byte/half/word, signed/unsigned) into word-addressed BRAM accesses with lane steering and byte enables.
- Returns load data extracted and extended, or a store acknowledge, over a valid/ready response channel.
- Sits between a core's LSU and a BRAM bank.

Parameters:
- DATA_WIDTH, 32, BRAM word width; only 32 is supported.
- ADDR_WIDTH, 8, BRAM word-address width; the request byte address is ADDR_WIDTH+2 bits.
- NUM_BYTES, DATA_WIDTH/8, number of byte lanes and the width of writeByteEnable.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when high together with req_valid.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_WIDTH+2  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  DATA_WIDTH  load result; 0 for stores and errors.
- resp_error  output  1  illegal size or misaligned access.
- readEnable  output  1  BRAM read strobe.
- readAddress  output  ADDR_WIDTH  BRAM read word address.
- readData  input  DATA_WIDTH  BRAM read data, valid one cycle after readEnable is sampled.
- writeEnable  output  1  BRAM write strobe.
- writeByteEnable  output  NUM_BYTES  BRAM lane mask.
- writeAddress  output  ADDR_WIDTH  BRAM write word address.
- writeData  output  DATA_WIDTH  lane-replicated store data.

Behaviour:
- All BRAM-side and response outputs are registered.
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - Every output is 0, including writeByteEnable=0 and req_ready=0 while reset is asserted.
  - req_ready rises in the first cycle after reset is released.
  - Reset mid-operation aborts it: no pending write is issued and any pending response is discarded.
- States: IDLE, ISSUE, WAIT, RESP.
  - IDLE: req_ready=1. On accept, latch the request. Word address = req_addr[ADDR_WIDTH+1:2]; offset = req_addr[1:0].
  - Error check: size 11, half with offset[0]=1, or word with offset≠0 -> go to RESP with resp_error=1 and resp_rdata=0. No BRAM strobe is issued.
  - Otherwise -> ISSUE.
  - ISSUE, one cycle:
    - Load: readEnable=1, readAddress=word address. Next state WAIT.
    - Store: writeEnable=1, writeAddress=word address. Next state RESP.
    - Byte store: writeData = wdata[7:0] replicated 4x; writeByteEnable = 0001 << offset.
    - Half store: writeData = wdata[15:0] replicated 2x; writeByteEnable = 0011 << offset.
    - Word store: writeData = wdata; writeByteEnable = 1111.
  - WAIT: strobes are 0. At the next edge, readData is extracted and stored in resp_rdata; next state RESP.
    - Byte extract: readData[8*offset+7 : 8*offset].
    - Half extract: readData[16*offset[1]+15 : 16*offset[1]].
    - Word: readData unchanged.
    - Extension is sign or zero per req_unsigned; word loads ignore req_unsigned.
  - RESP: resp_valid=1; resp_rdata and resp_error are held stable until resp_ready=1. On handshake -> IDLE and resp_valid drops.
- Strobes are high for exactly one cycle per access. readEnable and writeEnable are never high together.
- Latency, counted from the accept edge:
  - Load: resp_valid is high 3 edges later.
  - Store: resp_valid is high 2 edges later (the write commits at edge +2).
  - Error: resp_valid is high 1 edge later.
- With resp_ready held high, a new request is accepted in the cycle after the response handshake. Throughput is one access per 4 cycles for loads and 3 cycles for stores.
- Addresses wrap modulo 2^(ADDR_WIDTH+2); there is no bounds error.

Test Plan:
- Reset while in ISSUE with a store pending -> writeEnable never pulses; all outputs 0; req_ready=1 in the first cycle after release.
- Preload word 2 = 0xAAAA8888; load word at addr 0x08 -> resp_rdata=0xAAAA8888, resp_valid 3 cycles after accept.
- Store byte 0xBB at addr 0x0B (word 2 = 0x00000064) -> writeByteEnable=1000, writeData=0xBBBBBBBB; later word load returns 0xBB000064.
- Word 2 = 0xCCCC8888: signed half load at 0x08 -> 0xFFFF8888; unsigned half load at 0x0A -> 0x0000CCCC; signed byte load at 0x09 -> 0xFFFFFF88.
- Half load at 0x05, and a request with size=11 -> resp_error=1, resp_rdata=0 one cycle after accept; no readEnable/writeEnable pulse.
- Hold resp_ready=0 for 5 cycles on a load -> resp_valid and resp_rdata stable and req_ready=0 throughout; after the handshake, the next request is accepted in the following cycle.
